btn_event_ctrl: RTL

Input-event controller for the board push-buttons feeding the processor's input path. Debounces `N_BTN` raw button lines with one shared timebase, turns debounced presses into pending events, and offers them one at a time to the CPU side over a valid/ack handshake. Arbitration is round-robin. Lost presses are flagged per channel.

---
 rtl/btn_defs.sv | 21 ++
 rtl/btn_channel.sv | 76 +++++++
 rtl/btn_event_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/btn_defs.sv
`default_nettype none
// ============================================================================
//  Module      : btn_defs (package)
//  Description : Shared defaults and arbiter state encoding for the
//                push-button event controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_defs;

    // 1 ms debounce tick at a 38 MHz system clock
    localparam int DEF_TICK_DIV     = 38000;
    // 32 ms of continuous disagreement before a new level is accepted
    localparam int DEF_STABLE_TICKS = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_e;

endpackage : btn_defs
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ============================================================================
//  Module      : btn_channel
//  Description : One button lane: 2-FF synchroniser, tick-based stable
//                counter, debounced level and a one-cycle press pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_channel
    import btn_defs::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clk,
    input  logic n_reset,
    input  logic i_btn_raw,
    input  logic i_enable,
    input  logic i_tick,
    output logic o_btn_state,
    output logic o_rise
);

    localparam int               CNT_W      = $clog2(STABLE_TICKS);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_state;
    logic             r_rise;

    logic w_sync;
    logic w_differ;
    logic w_accept;

    assign w_sync   = r_sync[1];
    assign w_differ = (w_sync != r_state);
    // The STABLE_TICKS-th tick of uninterrupted disagreement flips the level
    assign w_accept = i_enable && w_differ && i_tick && (r_cnt == C_CNT_LAST);

    // Two-flop synchroniser for the asynchronous raw level
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], i_btn_raw};
        end
    end

    // Count ticks of disagreement; any agreeing cycle restarts the count
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_cnt <= '0;
        end else if (!i_enable || !w_differ || w_accept) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Debounced level and a pulse marking an accepted 0->1 change
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_state <= w_sync;
            end
            r_rise <= w_accept && w_sync;
        end
    end

    assign o_btn_state = r_state;
    assign o_rise      = r_rise;

endmodule : btn_channel
`default_nettype wire

// File: rtl/btn_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : btn_event_ctrl
//  Description : Debounces N_BTN push-buttons on a shared tick, queues one
//                pending event per channel and offers them round-robin over
//                a valid/ack handshake. Lost presses set sticky overflow bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_event_ctrl
    import btn_defs::*;
#(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int ID_W         = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             enable,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    input  logic             evt_ack,
    output logic [N_BTN-1:0] btn_state,
    output logic [N_BTN-1:0] overflow,
    input  logic             overflow_clr
);

    localparam int               PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [ID_W-1:0]  C_LAST_RST = ID_W'(N_BTN - 1);

    logic [PRE_W-1:0] r_pre;
    logic [N_BTN-1:0] r_pending;
    logic [N_BTN-1:0] r_overflow;
    arb_state_e       r_arb;
    logic             r_evt_valid;
    logic [ID_W-1:0]  r_evt_id;
    logic [ID_W-1:0]  r_last_grant;

    logic             w_tick;
    logic [N_BTN-1:0] w_state;
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_ack_clr;
    logic [N_BTN-1:0] w_ovf_set;
    arb_state_e       w_arb_nxt;
    logic             w_valid_nxt;
    logic [ID_W-1:0]  w_id_nxt;
    logic [ID_W-1:0]  w_last_nxt;
    logic             w_found;
    logic [ID_W-1:0]  w_win;
    logic [ID_W-1:0]  w_cand;

    // Shared debounce timebase; parked at zero while debouncing is disabled
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_pre <= '0;
        end else if (!enable || (r_pre == C_PRE_LAST)) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    assign w_tick = enable && (r_pre == C_PRE_LAST);

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
            btn_channel #(
                .STABLE_TICKS (STABLE_TICKS)
            ) u_chan (
                .clk         (clk),
                .n_reset     (n_reset),
                .i_btn_raw   (btn_raw[gi]),
                .i_enable    (enable),
                .i_tick      (w_tick),
                .o_btn_state (w_state[gi]),
                .o_rise      (w_rise[gi])
            );
        end
    endgenerate

    // Channel whose pending bit is retired by this cycle's acknowledge
    always_comb begin
        w_ack_clr = '0;
        if ((r_arb == ST_OFFER) && evt_ack) begin
            w_ack_clr[r_evt_id] = 1'b1;
        end
    end

    // A press on a channel that is still queued (and not retiring) is lost
    assign w_ovf_set = w_rise & r_pending & ~w_ack_clr;

    // Pending queue and sticky overflow; a new overflow beats a clear
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_pending  <= '0;
            r_overflow <= '0;
        end else begin
            r_pending  <= (r_pending & ~w_ack_clr) | w_rise;
            r_overflow <= (overflow_clr ? '0 : r_overflow) | w_ovf_set;
        end
    end

    // Round-robin pick and handshake next-state
    always_comb begin
        w_arb_nxt   = r_arb;
        w_valid_nxt = r_evt_valid;
        w_id_nxt    = r_evt_id;
        w_last_nxt  = r_last_grant;
        w_found     = 1'b0;
        w_win       = '0;
        w_cand      = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            w_cand = ID_W'((int'(r_last_grant) + k) % N_BTN);
            if (!w_found && r_pending[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
        case (r_arb)
            ST_IDLE: begin
                if (w_found) begin
                    w_arb_nxt   = ST_OFFER;
                    w_valid_nxt = 1'b1;
                    w_id_nxt    = w_win;
                end
            end
            ST_OFFER: begin
                if (evt_ack) begin
                    w_arb_nxt   = ST_IDLE;
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = r_evt_id;
                end
            end
            default: begin
                w_arb_nxt   = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // Arbiter registers; last_grant starts at the top so channel 0 goes first
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_arb        <= ST_IDLE;
            r_evt_valid  <= 1'b0;
            r_evt_id     <= '0;
            r_last_grant <= C_LAST_RST;
        end else begin
            r_arb        <= w_arb_nxt;
            r_evt_valid  <= w_valid_nxt;
            r_evt_id     <= w_id_nxt;
            r_last_grant <= w_last_nxt;
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;
    assign btn_state = w_state;
    assign overflow  = r_overflow;

endmodule : btn_event_ctrl
`default_nettype wire
